edge_proc_gen: RTL and testbench

Parametrised successor to the fixed 80x60 Sobel engine in the OV7670 filter pipeline. On a start pulse it processes exactly one frame: it reads the gray frame buffer, applies a 3x3 Sobel kernel and writes the result to the processed frame buffer, then pulses done. Image size, pixel width and border value are parametrised. Modes cover passthrough, horizontal, vertical and combined magnitude, each with optional thresholding. It sits between the camera frame buffer and the VGA display buffer and is started once per frame by the capture controller.

---
 rtl/edge_proc_gen.sv | 243 ++++++++++++++++++++++++
 tb/tb_edge_proc_gen.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_proc_gen.sv
// -----------------------------------------------------------------------------
// edge_proc_gen
//
// Single-frame 3x3 Sobel engine. A start pulse runs one pass over the gray
// frame buffer: pixels are streamed in raster order, a 3x3 window is built
// from two line delays, and the filtered result is written in ascending
// address order to the processed frame buffer. done pulses once the final
// write has completed.
//
// Ports
//   clk        single clock domain
//   rst        synchronous active-low reset
//   start      one-cycle request, honoured only while idle
//   mode       [1:0] 00 passthrough, 01 horizontal, 10 vertical, 11 magnitude
//              [2]   threshold enable (captured with start)
//   thresh     threshold level (captured with start)
//   orig_addr  read address into the gray frame buffer
//   orig_pxl   read data, valid one cycle after orig_addr; gray = low c_pxl_w bits
//   proc_we    write strobe for the processed frame buffer
//   proc_addr  registered write address
//   proc_pxl   registered write data
//   busy       high while a frame is being processed
//   done       one-cycle pulse after the final write
// -----------------------------------------------------------------------------
module edge_proc_gen #(
  parameter int c_img_cols    = 80,
  parameter int c_img_rows    = 60,
  parameter int c_nb_img_pxls = 13,
  parameter int c_nb_buf      = 12,
  parameter int c_pxl_w       = 8,
  parameter int c_border_val  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               mode,
  input  logic [c_pxl_w-1:0]       thresh,
  output logic [c_nb_img_pxls-1:0] orig_addr,
  input  logic [c_nb_buf-1:0]      orig_pxl,
  output logic                     proc_we,
  output logic [c_nb_img_pxls-1:0] proc_addr,
  output logic [c_pxl_w-1:0]       proc_pxl,
  output logic                     busy,
  output logic                     done
);

  localparam int c_p        = c_img_cols * c_img_rows;
  localparam int c_n_end    = c_p + c_img_cols + 3;
  // Run cycle in which the window is centred on pixel 0.
  localparam int c_k_first  = c_img_cols + 3;
  localparam int c_nb_n     = $clog2(c_n_end + 1);
  localparam int c_col_w    = $clog2(c_img_cols);
  localparam int c_row_w    = $clog2(c_img_rows);
  localparam int c_sum_w    = c_pxl_w + 3;
  localparam int c_lb_depth = c_img_cols - 3;

  localparam logic [c_sum_w-1:0] c_pxl_max = {3'b000, {c_pxl_w{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                     state_q,  state_d;
  logic [c_nb_n-1:0]          n_q,      n_d;
  logic [2:0]                 mode_q,   mode_d;
  logic [c_pxl_w-1:0]         thresh_q, thresh_d;
  logic [c_col_w-1:0]         col_q,    col_d;
  logic [c_row_w-1:0]         row_q,    row_d;
  logic [c_nb_img_pxls-1:0]   k_q,      k_d;
  logic                       we_q,     we_d;
  logic [c_nb_img_pxls-1:0]   addr_q,   addr_d;
  logic [c_pxl_w-1:0]         pxl_q,    pxl_d;

  // 3x3 window: p0x upper (oldest) row, p2x lower (newest) row, px2 newest column.
  logic [c_pxl_w-1:0] p00_q, p01_q, p02_q;
  logic [c_pxl_w-1:0] p10_q, p11_q, p12_q;
  logic [c_pxl_w-1:0] p20_q, p21_q, p22_q;
  logic [c_pxl_w-1:0] lb_mid_q [c_lb_depth];
  logic [c_pxl_w-1:0] lb_top_q [c_lb_depth];

  // Only the low c_pxl_w bits of the stored word carry gray data.
  generate
    if (c_nb_buf > c_pxl_w) begin : g_gray_hi
      logic unused_gray_hi;
      assign unused_gray_hi = ^orig_pxl[c_nb_buf-1:c_pxl_w];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sliding window. Each line delay plus the register after it spans
  // c_img_cols-2 stages, so with the two in-row shifts every row of the
  // window lies exactly one image line behind the row below it.
  // NOTE: the window and line buffers have no reset; every value that feeds
  // an interior result is refilled from the current frame before it is used,
  // so reset would only add fan-out to plain shift storage.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    p22_q <= orig_pxl[c_pxl_w-1:0];
    p21_q <= p22_q;
    p20_q <= p21_q;
    lb_mid_q[0] <= p20_q;
    for (int i = 1; i < c_lb_depth; i++) lb_mid_q[i] <= lb_mid_q[i-1];
    p12_q <= lb_mid_q[c_lb_depth-1];
    p11_q <= p12_q;
    p10_q <= p11_q;
    lb_top_q[0] <= p10_q;
    for (int i = 1; i < c_lb_depth; i++) lb_top_q[i] <= lb_top_q[i-1];
    p02_q <= lb_top_q[c_lb_depth-1];
    p01_q <= p02_q;
    p00_q <= p01_q;
  end

  // ---------------------------------------------------------------------------
  // Sobel arithmetic
  // ---------------------------------------------------------------------------
  function automatic logic [c_sum_w-1:0] wsum(input logic [c_pxl_w-1:0] a,
                                               input logic [c_pxl_w-1:0] b,
                                               input logic [c_pxl_w-1:0] c);
    return c_sum_w'(a) + (c_sum_w'(b) << 1) + c_sum_w'(c);
  endfunction

  function automatic logic [c_sum_w-1:0] absdiff(input logic [c_sum_w-1:0] a,
                                                  input logic [c_sum_w-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [c_sum_w-1:0] h_abs, v_abs, sel_val;
  logic [c_pxl_w-1:0] sat_val, thr_val, out_val;
  logic               border, k_valid;

  always_comb begin
    h_abs = absdiff(wsum(p20_q, p21_q, p22_q), wsum(p00_q, p01_q, p02_q));
    v_abs = absdiff(wsum(p02_q, p12_q, p22_q), wsum(p00_q, p10_q, p20_q));
    case (mode_q[1:0])
      2'b01:   sel_val = h_abs;
      2'b10:   sel_val = v_abs;
      2'b11:   sel_val = h_abs + v_abs;
      default: sel_val = c_sum_w'(p11_q);
    endcase
    sat_val = (sel_val > c_pxl_max) ? {c_pxl_w{1'b1}} : sel_val[c_pxl_w-1:0];
    if (mode_q[2]) thr_val = (sat_val >= thresh_q) ? {c_pxl_w{1'b1}} : '0;
    else           thr_val = sat_val;
    border = (row_q == '0) || (row_q == c_row_w'(c_img_rows - 1)) ||
             (col_q == '0) || (col_q == c_col_w'(c_img_cols - 1));
    // Passthrough keeps the original border pixels.
    out_val = ((mode_q[1:0] != 2'b00) && border) ? c_pxl_w'(c_border_val) : thr_val;
  end

  assign k_valid = (state_q == S_RUN) &&
                   (n_q >= c_nb_n'(c_k_first)) && (n_q < c_nb_n'(c_n_end));

  // ---------------------------------------------------------------------------
  // Control FSM and output stage
  // NOTE: every signal below gets a default before the case statement so no
  // path leaves one unassigned and no latch is inferred.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    mode_d   = mode_q;
    thresh_d = thresh_q;
    col_d    = col_q;
    row_d    = row_q;
    k_d      = k_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    pxl_d    = pxl_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          n_d      = '0;
          mode_d   = mode;
          thresh_d = thresh;
          col_d    = '0;
          row_d    = '0;
          k_d      = '0;
        end
      end
      S_RUN: begin
        if (n_q == c_nb_n'(c_n_end)) state_d = S_DONE;
        else                         n_d     = n_q + 1'b1;
        if (k_valid) begin
          we_d   = 1'b1;
          addr_d = k_q;
          pxl_d  = out_val;
          k_d    = k_q + 1'b1;
          // Row/column of the centre pixel tracked incrementally (no divider).
          if (col_q == c_col_w'(c_img_cols - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      mode_q   <= '0;
      thresh_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      k_q      <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      pxl_q    <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      mode_q   <= mode_d;
      thresh_q <= thresh_d;
      col_q    <= col_d;
      row_q    <= row_d;
      k_q      <= k_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      pxl_q    <= pxl_d;
    end
  end

  // Reads past the last pixel only feed last-row (border) kernels, so the
  // address simply parks on the final pixel during the flush.
  assign orig_addr = (n_q >= c_nb_n'(c_p - 1)) ? c_nb_img_pxls'(c_p - 1)
                                               : c_nb_img_pxls'(n_q);
  assign proc_we   = we_q;
  assign proc_addr = addr_q;
  assign proc_pxl  = pxl_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_edge_proc_gen.sv
// -----------------------------------------------------------------------------
// tb_edge_proc_gen
//
// Bench for edge_proc_gen on an 8x6 image with border value 5. Frame buffers
// are modelled here; a monitor records every write. Expected pixels come from
// a direct 2-D Sobel computation over the source image.
// -----------------------------------------------------------------------------
module tb_edge_proc_gen;

  localparam int COLS   = 8;
  localparam int ROWS   = 6;
  localparam int P      = COLS * ROWS;
  localparam int NB     = 6;
  localparam int NBUF   = 12;
  localparam int PW     = 8;
  localparam int BORDER = 5;

  localparam int PAT_PTR  = 0;  // image[k] = k (random upper bits)
  localparam int PAT_UNI  = 1;  // all 77
  localparam int PAT_STEP = 2;  // cols 0..3 = 0, cols 4..7 = 100
  localparam int PAT_RAMP = 3;  // 5*(r+c): H = V = 40 inside
  localparam int PAT_RAND = 4;

  logic            clk    = 1'b0;
  logic            rst    = 1'b0;
  logic            start  = 1'b0;
  logic [2:0]      mode   = '0;
  logic [PW-1:0]   thresh = '0;
  logic [NB-1:0]   orig_addr;
  logic [NBUF-1:0] orig_pxl;
  logic            proc_we;
  logic [NB-1:0]   proc_addr;
  logic [PW-1:0]   proc_pxl;
  logic            busy;
  logic            done;

  edge_proc_gen #(
    .c_img_cols   (COLS),
    .c_img_rows   (ROWS),
    .c_nb_img_pxls(NB),
    .c_nb_buf     (NBUF),
    .c_pxl_w      (PW),
    .c_border_val (BORDER)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .thresh   (thresh),
    .orig_addr(orig_addr),
    .orig_pxl (orig_pxl),
    .proc_we  (proc_we),
    .proc_addr(proc_addr),
    .proc_pxl (proc_pxl),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Frame buffers
  logic [NBUF-1:0] img   [P];
  logic [PW-1:0]   pmem  [P];
  int              stamp [P];
  int              frame_no  = 0;
  int              wr_cnt    = 0;
  int              order_err = 0;
  logic [NB-1:0]   last_addr;

  int n_checks = 0;
  int n_errors = 0;

  always @(posedge clk) orig_pxl <= img[orig_addr];

  // Write monitor: stores data and flags any write that is not the next
  // ascending address (wrapping to 0 after P-1 or after a reset).
  always @(posedge clk) begin
    if (proc_we) begin
      wr_cnt <= wr_cnt + 1;
      if (int'(proc_addr) != ((int'(last_addr) == P - 1) ? 0 : int'(last_addr) + 1))
        order_err <= order_err + 1;
      if (int'(proc_addr) < P) begin
        pmem[proc_addr]  <= proc_pxl;
        stamp[proc_addr] <= frame_no;
      end
    end
    if (!rst)         last_addr <= NB'(P - 1);
    else if (proc_we) last_addr <= proc_addr;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int gray(input int r, input int c);
    return int'(img[r * COLS + c][PW-1:0]);
  endfunction

  function automatic int ref_pxl(input int k, input logic [2:0] m, input int t);
    int r, c, h, v, f;
    r = k / COLS;
    c = k % COLS;
    if (m[1:0] == 2'b00) begin
      f = gray(r, c);
    end else begin
      if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) return BORDER;
      h = (gray(r+1, c-1) + 2 * gray(r+1, c) + gray(r+1, c+1))
        - (gray(r-1, c-1) + 2 * gray(r-1, c) + gray(r-1, c+1));
      v = (gray(r-1, c+1) + 2 * gray(r, c+1) + gray(r+1, c+1))
        - (gray(r-1, c-1) + 2 * gray(r, c-1) + gray(r+1, c-1));
      if (h < 0) h = -h;
      if (v < 0) v = -v;
      f = (m[1:0] == 2'b01) ? h : (m[1:0] == 2'b10) ? v : h + v;
      if (f > 255) f = 255;
    end
    if (m[2]) f = (f >= t) ? 255 : 0;
    return f;
  endfunction

  task automatic fill_img(input int pat);
    for (int k = 0; k < P; k++) begin
      int r, c;
      r = k / COLS;
      c = k % COLS;
      case (pat)
        PAT_PTR:  img[k] = {4'($urandom), 8'(k)};
        PAT_UNI:  img[k] = 12'd77;
        PAT_STEP: img[k] = (c < 4) ? 12'd0 : 12'd100;
        PAT_RAMP: img[k] = 12'(5 * (r + c));
        default:  img[k] = 12'($urandom);
      endcase
    end
  endtask

  // ---------------------------------------------------------------------------
  // One frame. Called and returns at a negedge in an idle cycle.
  //   abort_at : run cycle during which rst is held low (-1 = none)
  //   extra_at : run cycle during which a spurious start is raised (-1 = none)
  //   b2b      : raise start in the done cycle and keep it for the next frame
  // ---------------------------------------------------------------------------
  task automatic run_frame(input logic [2:0] m, input logic [7:0] t,
                           input int abort_at, input int extra_at, input bit b2b);
    int done_cyc, busy_low, base_wr, base_oerr;
    frame_no++;
    base_wr   = wr_cnt;
    base_oerr = order_err;
    mode   = m;
    thresh = t;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // mode/thresh must have been captured with start.
    start  = 1'b0;
    mode   = 3'($urandom);
    thresh = 8'($urandom);
    check("busy_rise", int'(busy), 1);
    done_cyc = -1;
    busy_low = 0;
    for (int c = 0; c < 200; c++) begin
      if (done) begin
        done_cyc = c;
        break;
      end
      if (!busy) busy_low++;
      start = (c == extra_at);
      rst   = (c != abort_at);
      @(negedge clk);
    end
    start = 1'b0;
    rst   = 1'b1;
    if (abort_at >= 0) begin
      check("abort_no_done", done_cyc, -1);
      check("abort_busy", int'(busy), 0);
      check("abort_we", int'(proc_we), 0);
      // Writes occur in run cycles COLS+4 .. abort_at inclusive.
      check("abort_wr_cnt", wr_cnt - base_wr, abort_at - (COLS + 4) + 1);
    end else begin
      check("done_cycle", done_cyc, P + COLS + 4);
      check("busy_in_done", int'(busy), 0);
      check("busy_gaps", busy_low, 0);
      if (b2b) start = 1'b1;
      @(negedge clk);
      check("done_width", int'(done), 0);
      check("idle_after_done", int'(busy), 0);
      check("wr_cnt", wr_cnt - base_wr, P);
      check("wr_order", order_err - base_oerr, 0);
      for (int k = 0; k < P; k++)
        check($sformatf("pxl[%0d]", k),
              (stamp[k] == frame_no) ? int'(pmem[k]) : -1, ref_pxl(k, m, int'(t)));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: pattern, mode, threshold, two probe pixels with values
  // worked out by hand.
  // ---------------------------------------------------------------------------
  typedef struct {
    int         pat;
    logic [2:0] md;
    logic [7:0] thr;
    int         ka;
    int         va;
    int         kb;
    int         vb;
  } vec_t;

  vec_t vecs [11];
  logic [PW-1:0] saved [P];

  initial begin
    int diff;
    vecs[0]  = '{PAT_PTR,  3'b000, 8'd0,  20, 20,  0,  0};       // border not forced
    vecs[1]  = '{PAT_UNI,  3'b001, 8'd0,   9,  0,  0,  BORDER};
    vecs[2]  = '{PAT_UNI,  3'b010, 8'd0,  20,  0, 47,  BORDER};
    vecs[3]  = '{PAT_UNI,  3'b011, 8'd0,  30,  0,  7,  BORDER};
    vecs[4]  = '{PAT_STEP, 3'b010, 8'd0,  19, 255, 18, 0};       // col 3 / col 2
    vecs[5]  = '{PAT_STEP, 3'b010, 8'd0,  12, 255, 30, 0};       // col 4 / col 6
    vecs[6]  = '{PAT_STEP, 3'b001, 8'd0,  19,  0,  0,  BORDER};
    vecs[7]  = '{PAT_RAMP, 3'b011, 8'd0,   9, 80, 40,  BORDER};
    vecs[8]  = '{PAT_RAMP, 3'b111, 8'd80, 20, 255, 0,  BORDER};
    vecs[9]  = '{PAT_RAMP, 3'b111, 8'd81, 20,  0, 47,  BORDER};
    vecs[10] = '{PAT_PTR,  3'b100, 8'd30, 30, 255, 29, 0};       // passthrough threshold

    fill_img(PAT_PTR);
    repeat (3) @(negedge clk);
    check("rst_we",        int'(proc_we),   0);
    check("rst_addr",      int'(proc_addr), 0);
    check("rst_pxl",       int'(proc_pxl),  0);
    check("rst_busy",      int'(busy),      0);
    check("rst_done",      int'(done),      0);
    check("rst_orig_addr", int'(orig_addr), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      fill_img(vecs[i].pat);
      run_frame(vecs[i].md, vecs[i].thr, -1, -1, 1'b0);
      check($sformatf("vec%0d_a", i), int'(pmem[vecs[i].ka]), vecs[i].va);
      check($sformatf("vec%0d_b", i), int'(pmem[vecs[i].kb]), vecs[i].vb);
    end

    // Random images, modes and thresholds against the model.
    for (int i = 0; i < 6; i++) begin
      fill_img(PAT_RAND);
      run_frame(3'($urandom), 8'($urandom_range(0, 255)), -1, -1, 1'b0);
    end

    // Back-to-back: start held through the done cycle (ignored) and the
    // following idle cycle (accepted); both frames must match.
    fill_img(PAT_STEP);
    run_frame(3'b011, 8'd0, -1, -1, 1'b1);
    for (int k = 0; k < P; k++) saved[k] = pmem[k];
    run_frame(3'b011, 8'd0, -1, -1, 1'b0);
    diff = 0;
    for (int k = 0; k < P; k++) if (saved[k] != pmem[k]) diff++;
    check("b2b_same", diff, 0);

    // Start during busy is ignored and the frame length is unchanged.
    fill_img(PAT_RAND);
    run_frame(3'b010, 8'd0, -1, 20, 1'b0);

    // Reset in run cycle 30 aborts; the next frame is complete.
    fill_img(PAT_PTR);
    run_frame(3'b000, 8'd0, 30, -1, 1'b0);
    check("abort_orig_addr", int'(orig_addr), 0);
    fill_img(PAT_RAMP);
    run_frame(3'b011, 8'd0, -1, -1, 1'b0);
    check("post_abort_interior", int'(pmem[27]), 80);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
